width_conv_arbiter: RTL and testbench

Shares one 8-to-12 width converter between NREQ byte-stream requesters. Grants one requester at a time, round-robin. Each grant always feeds the converter a whole number of GROUP-byte frames, so the converter's internal byte position is at frame start whenever ownership changes. A short final group is zero-padded. Sits directly upstream of the converter, which has no backpressure, so this block is the sole source of its a_vld/a.

---
 rtl/width_conv_pkg.sv | 40 ++++
 rtl/width_conv_arbiter_rr_arbiter.sv | 41 ++++
 rtl/width_conv_arbiter.sv | 158 +++++++++++++++
 tb/tb_width_conv_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/width_conv_pkg.sv
// Shared types and helpers for the byte-stream arbiter feeding the 8-to-12 converter.
package width_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  // Converter input buffer width; one frame fills it completely.
  localparam int CONV_BUF_W = 24;

  // Widest requester vector the pick helper handles.
  localparam int RR_MAX = 16;

  // Bytes per converter frame.
  function automatic int group_of(input int buf_width, input int awidth);
    return buf_width / awidth;
  endfunction

  // First set request at or above ptr, wrapping at nreq.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                nreq);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k < nreq) && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/width_conv_arbiter_rr_arbiter.sv
// Combinational round-robin pick with a registered rotating pointer.
module rr_arbiter
  import width_conv_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic            any,
  output logic [IDW-1:0]  pick
);

  logic [IDW-1:0]    rr_ptr;
  logic [RR_MAX-1:0] req_w;
  logic [3:0]        ptr_w;
  logic [3:0]        pick_w;

  // Widen to the helper's fixed width and pick from the current pointer.
  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
    ptr_w            = '0;
    ptr_w[IDW-1:0]   = rr_ptr;
    pick_w           = rr_pick(req_w, ptr_w, NREQ);
    pick             = pick_w[IDW-1:0];
    any              = |req;
  end

  // Pointer moves just past the winner whenever a grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
    end
  end

endmodule

// File: rtl/width_conv_arbiter.sv
// Grants one byte-stream requester at a time to the shared width converter,
// always handing over ownership on a frame boundary (short frames zero-padded).
module width_conv_arbiter
  import width_conv_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AWIDTH    = 8,
  parameter int GROUP     = group_of(CONV_BUF_W, AWIDTH),
  parameter int MAX_BURST = 12,
  parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*AWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_rdy,
  output logic                   conv_vld,
  output logic [AWIDTH-1:0]      conv_data,
  output logic [IDW-1:0]         conv_owner,
  output logic                   conv_sof,
  output logic                   conv_pad,
  output logic                   busy
);

  localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [GW-1:0] GRP_LAST   = GW'(GROUP - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  if (MAX_BURST <= 0 || (MAX_BURST % GROUP) != 0) begin : g_bad_burst
    $error("MAX_BURST must be a nonzero multiple of GROUP");
  end
  if (NREQ < 2 || NREQ > RR_MAX) begin : g_bad_nreq
    $error("NREQ must be in 2..16");
  end

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    grant;
  logic              arb_any;
  logic [IDW-1:0]    arb_pick;
  logic              arb_advance;
  logic              sel_vld;
  logic              sel_last;
  logic [AWIDTH-1:0] sel_data;
  logic              accept;
  logic [GW-1:0]     grp_cnt;
  logic [GW-1:0]     grp_inc;
  logic [BW-1:0]     burst_cnt;
  logic              grp_end;
  logic              burst_end;

  assign arb_advance = (state == IDLE) && arb_any;
  assign accept      = (state == XFER) && sel_vld;
  assign grp_end     = (grp_cnt == GRP_LAST);
  assign burst_end   = (burst_cnt == BURST_LAST);
  assign grp_inc     = grp_end ? '0 : grp_cnt + 1'b1;
  assign busy        = (state != IDLE);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vld),
    .advance (arb_advance),
    .any     (arb_any),
    .pick    (arb_pick)
  );

  // Route the granted requester's byte, valid and last flag.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
        sel_data = req_data[i*AWIDTH +: AWIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave XFER only on an accepted byte, never mid-frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_any) state_nxt = XFER;
      XFER: begin
        if (accept) begin
          if (sel_last)       state_nxt = grp_end ? IDLE : PAD;
          else if (burst_end) state_nxt = IDLE;
        end
      end
      PAD:  if (grp_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept strobe goes only to the owner while transferring.
  always_comb begin
    req_rdy = '0;
    if (state == XFER) req_rdy[grant] = 1'b1;
  end

  // ---- stage p0 -> p1: grant/counters and registered converter drive ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      grp_cnt    <= '0;
      burst_cnt  <= '0;
      conv_vld   <= 1'b0;
      conv_data  <= '0;
      conv_owner <= '0;
      conv_sof   <= 1'b0;
      conv_pad   <= 1'b0;
    end else begin
      conv_vld <= 1'b0;
      conv_sof <= 1'b0;
      conv_pad <= 1'b0;
      case (state)
        IDLE: begin
          grp_cnt   <= '0;
          burst_cnt <= '0;
          if (arb_any) grant <= arb_pick;
        end
        XFER: begin
          if (accept) begin
            conv_vld   <= 1'b1;
            conv_data  <= sel_data;
            conv_owner <= grant;
            conv_sof   <= (burst_cnt == '0);
            grp_cnt    <= grp_inc;
            burst_cnt  <= burst_cnt + 1'b1;
          end
        end
        PAD: begin
          conv_vld   <= 1'b1;
          conv_data  <= '0;
          conv_owner <= grant;
          conv_pad   <= 1'b1;
          grp_cnt    <= grp_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_width_conv_arbiter.sv
// Directed bench for width_conv_arbiter with a packet-level reference model.
module tb_width_conv_arbiter;

  localparam int NREQ      = 4;
  localparam int AWIDTH    = 8;
  localparam int GROUP     = 3;
  localparam int MAX_BURST = 12;
  localparam int IDW       = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_vld;
  logic [NREQ*AWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_rdy;
  logic                   conv_vld;
  logic [AWIDTH-1:0]      conv_data;
  logic [IDW-1:0]         conv_owner;
  logic                   conv_sof;
  logic                   conv_pad;
  logic                   busy;

  width_conv_arbiter #(
    .NREQ(NREQ), .AWIDTH(AWIDTH), .GROUP(GROUP), .MAX_BURST(MAX_BURST), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .conv_vld(conv_vld), .conv_data(conv_data), .conv_owner(conv_owner),
    .conv_sof(conv_sof), .conv_pad(conv_pad), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         own;
    bit         sof;
    bit         pad;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] drv_q [NREQ][$];
  int stall_after [NREQ];
  int stall_len   [NREQ];
  int stall_cnt   [NREQ];
  int acc_cnt     [NREQ];
  int n_cmp = 0, n_fail = 0, cyc = 0, m_rr = 0, acc_first = -1;
  logic [7:0] cap_d   [$];
  int         cap_own [$];
  int         cap_cyc [$];
  bit         cap_sof [$];
  bit         cap_pad [$];

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requester drivers: pop on handshake, optional stall window after N bytes.
  initial begin
    logic [NREQ-1:0] hs;
    req_vld = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      stall_after[i] = -1; stall_len[i] = 0; stall_cnt[i] = 0; acc_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      hs = req_vld & req_rdy;
      if (hs != '0 && acc_first < 0) acc_first = cyc;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && !rst && drv_q[i].size() > 0) begin
          void'(drv_q[i].pop_front());
          acc_cnt[i]++;
          if (acc_cnt[i] == stall_after[i]) stall_cnt[i] = stall_len[i];
        end
        if (stall_cnt[i] > 0) begin
          req_vld[i] = 1'b0;
          stall_cnt[i]--;
        end else if (drv_q[i].size() > 0) begin
          req_vld[i] = 1'b1;
          req_data[i*AWIDTH +: AWIDTH] = drv_q[i][0][7:0];
          req_last[i] = drv_q[i][0][8];
        end else begin
          req_vld[i] = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Output checker against the model stream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rdy_onehot_when_busy", int'($onehot0(req_rdy) && (busy || req_rdy == '0)), 1);
      if (conv_vld) begin
        cap_d.push_back(conv_data);
        cap_own.push_back(int'(conv_owner));
        cap_cyc.push_back(cyc);
        cap_sof.push_back(conv_sof);
        cap_pad.push_back(conv_pad);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_byte: got data %02h owner %0d, required no byte", conv_data, conv_owner);
        end else begin
          e = exp_q.pop_front();
          chk("conv_data", conv_data, e.d);
          chk("conv_owner", conv_owner, e.own);
          chk("conv_sof", conv_sof, e.sof);
          chk("conv_pad", conv_pad, e.pad);
        end
      end
    end
  end

  // Packet-level model: round-robin over requesters with queued bytes,
  // burst ends on last or MAX_BURST bytes, short final frame zero-padded.
  task automatic build_model();
    logic [8:0] mq [NREQ][$];
    int g, n;
    logic [8:0] b;
    for (int i = 0; i < NREQ; i++) mq[i] = drv_q[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && mq[(m_rr + k) % NREQ].size() > 0) g = (m_rr + k) % NREQ;
      if (g < 0) break;
      m_rr = (g + 1) % NREQ;
      n = 0;
      while (mq[g].size() > 0) begin
        b = mq[g].pop_front();
        exp_q.push_back('{b[7:0], g, n == 0, 1'b0});
        n++;
        if (b[8]) begin
          for (int p = 0; p < (GROUP - n % GROUP) % GROUP; p++)
            exp_q.push_back('{8'h00, g, 1'b0, 1'b1});
          break;
        end
        if (n == MAX_BURST) break;
      end
    end
  endtask

  task automatic prepare();
    cap_d.delete(); cap_own.delete(); cap_cyc.delete(); cap_sof.delete(); cap_pad.delete();
    for (int i = 0; i < NREQ; i++) begin
      stall_after[i] = -1; stall_len[i] = 0; stall_cnt[i] = 0; acc_cnt[i] = 0;
    end
    acc_first = -1;
  endtask

  task automatic load(input int r, input int first, input int n, input bit with_last);
    for (int i = 0; i < n; i++)
      drv_q[r].push_back({(with_last && i == n - 1), 8'(first + i)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (all_empty() && exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    chk({nm, "_completed"}, ok, 1);
    chk({nm, "_model_left"}, exp_q.size(), 0);
  endtask

  function automatic int vec_of(input bit q [$]);
    int v;
    v = 0;
    for (int i = 0; i < q.size(); i++) if (q[i]) v |= (1 << i);
    return v;
  endfunction

  initial begin
    logic [23:0] w;
    bit ok;
    #1 rst = 1'b1;
    #2;
    chk("reset_conv_vld", conv_vld, 0);
    chk("reset_conv_data", conv_data, 0);
    chk("reset_conv_owner", conv_owner, 0);
    chk("reset_sof_pad", {conv_sof, conv_pad}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_rdy", req_rdy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin, all four requesting; req0 has two packets.
    prepare();
    load(0, 8'h01, 3, 1); load(0, 8'h41, 3, 1);
    load(1, 8'h11, 3, 1); load(2, 8'h21, 3, 1); load(3, 8'h31, 3, 1);
    build_model();
    wait_done("rr");
    chk("rr_count", cap_d.size(), 15);
    if (cap_d.size() == 15) begin
      chk("rr_order", {cap_own[0], cap_own[3], cap_own[6], cap_own[9], cap_own[12]} ,
          {32'd0, 32'd1, 32'd2, 32'd3, 32'd0});
      chk("rr_in_grant_spacing", cap_cyc[2] - cap_cyc[0], 2);
      chk("rr_idle_gap", cap_cyc[3] - cap_cyc[2], 2);
      chk("rr_second_pkt_data", cap_d[12], 8'h41);
    end

    // Single requester, two full frames.
    prepare();
    load(1, 8'h11, 6, 1);
    build_model();
    wait_done("single");
    chk("single_count", cap_d.size(), 6);
    if (cap_d.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("single_data", cap_d[i], 8'h11 + i);
      chk("single_sof_vec", vec_of(cap_sof), 6'b000001);
      chk("single_pad_vec", vec_of(cap_pad), 0);
      chk("single_owner", cap_own[5], 1);
      chk("single_latency", cap_cyc[0] - acc_first, 1);
      w = {cap_d[0], cap_d[1], cap_d[2]};
      chk("single_word0_hi", w[23:12], 12'h111);
      chk("single_word0_lo", w[11:0], 12'h213);
      w = {cap_d[3], cap_d[4], cap_d[5]};
      chk("single_word1_hi", w[23:12], 12'h141);
      chk("single_word1_lo", w[11:0], 12'h516);
    end

    // Short final frame padded with zeros.
    prepare();
    load(0, 8'hA1, 4, 1);
    build_model();
    wait_done("pad");
    chk("pad_count", cap_d.size(), 6);
    if (cap_d.size() == 6) begin
      chk("pad_vec", vec_of(cap_pad), 6'b110000);
      chk("pad_zero_bytes", {cap_d[4], cap_d[5]}, 16'h0000);
      chk("pad_owner", cap_own[5], 0);
    end

    // MAX_BURST cut with another requester waiting.
    prepare();
    load(2, 8'h40, 20, 1);
    load(3, 8'hC1, 3, 1);
    build_model();
    wait_done("burst");
    chk("burst_count", cap_d.size(), 24);
    if (cap_d.size() == 24) begin
      chk("burst_cut_owner", {cap_own[11], cap_own[12], cap_own[15]}, {32'd2, 32'd3, 32'd2});
      chk("burst_resume_sof", cap_sof[15], 1);
      chk("burst_resume_data", cap_d[15], 8'h4C);
      chk("burst_final_pad", cap_pad[23], 1);
      chk("burst_cut_gap", cap_cyc[12] - cap_cyc[11], 2);
    end

    // Requester bubbles mid-frame; grant and frame position held.
    prepare();
    stall_after[0] = 2; stall_len[0] = 5;
    load(0, 8'h51, 6, 1);
    build_model();
    wait_done("bubble");
    chk("bubble_count", cap_d.size(), 6);
    if (cap_d.size() == 6) begin
      chk("bubble_gap", cap_cyc[2] - cap_cyc[1], 6);
      chk("bubble_pad_vec", vec_of(cap_pad), 0);
      chk("bubble_sof_vec", vec_of(cap_sof), 6'b000001);
    end

    // Asynchronous reset mid-transfer, then arbitration restarts from req0.
    prepare();
    load(1, 8'h61, 6, 1);
    build_model();
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (cap_d.size() >= 2) begin ok = 1'b1; break; end
    end
    chk("rst_test_started", ok, 1);
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_conv_vld", conv_vld, 0);
    chk("rst_async_conv_data", conv_data, 0);
    chk("rst_async_owner_flags", {conv_owner, conv_sof, conv_pad}, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_req_rdy", req_rdy, 0);
    for (int i = 0; i < NREQ; i++) drv_q[i].delete();
    exp_q.delete();
    m_rr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prepare();
    load(3, 8'h81, 3, 1);
    load(0, 8'h71, 3, 1);
    build_model();
    wait_done("post_rst");
    chk("post_rst_count", cap_d.size(), 6);
    if (cap_d.size() == 6) begin
      chk("post_rst_first_owner", cap_own[0], 0);
      chk("post_rst_second_owner", cap_own[3], 3);
      chk("post_rst_first_data", cap_d[0], 8'h71);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
